// File: rtl/rv32i_mtimer_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_mtimer_pkg
//   Shared constants for the machine timer peripheral: register offsets on the
//   memory-mapped bus port, CTRL field positions and the mtime width.
//   Imported by rv32i_mtimer and mtimer_prescaler.
// -----------------------------------------------------------------------------
package rv32i_mtimer_pkg;

  // Width of the mtime / mtimecmp counters.
  localparam int MTIME_W = 48;

  // Byte offsets of the mapped registers. Only bits [4:2] take part in
  // decoding; bits [1:0] of the bus address are ignored.
  localparam logic [4:0] MTIMER_OFF_MTIME_LO = 5'h00;
  localparam logic [4:0] MTIMER_OFF_MTIME_HI = 5'h04;
  localparam logic [4:0] MTIMER_OFF_CMP_LO   = 5'h08;
  localparam logic [4:0] MTIMER_OFF_CMP_HI   = 5'h0C;
  localparam logic [4:0] MTIMER_OFF_CTRL     = 5'h10;

  // CTRL register layout: bit0 EN, DIV starts at bit 8.
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIV_LSB = 8;

  // Width of the high half of mtime as seen on the bus.
  localparam int MTIME_HI_W = MTIME_W - 32;

endpackage

// File: rtl/rv32i_mtimer_prescaler.sv
// -----------------------------------------------------------------------------
// mtimer_prescaler
//   Divides the core clock down to the mtime tick rate. While enabled the
//   count advances every cycle; when it equals DIV a one-cycle tick fires and
//   the count restarts at 0, so the tick period is DIV+1 cycles (DIV=0 ticks
//   every cycle). Disabling freezes the count.
//
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   en    in   CTRL.EN
//   div   in   CTRL.DIV, PRESC_W bits
//   clear in   restart the count at 0 (software wrote CTRL)
//   tick  out  one-cycle increment request for mtime
// -----------------------------------------------------------------------------
module mtimer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  input  logic               clear,
  output logic               tick
);

  logic [PRESC_W-1:0] count_q;

  // A CTRL write restarts the divider, so no tick is issued in that cycle;
  // the first tick after the write arrives DIV+1 cycles later.
  assign tick = en && !clear && (count_q == div);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (en) begin
      if (tick) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/rv32i_mtimer.sv
// -----------------------------------------------------------------------------
// rv32i_mtimer
//   Machine timer peripheral feeding the CSR file. Keeps the 48-bit mtime
//   count, compares it against mtimecmp to produce MTIP (timer_interrupt), and
//   exposes mtime, mtimecmp and CTRL through a single-cycle bus port.
//
//   Register map (byte offsets, bits [1:0] ignored):
//     0x00 MTIME_LO  mtime[31:0]
//     0x04 MTIME_HI  mtime[47:32] in bits [15:0]
//     0x08 CMP_LO    mtimecmp[31:0]
//     0x0C CMP_HI    mtimecmp[47:32] in bits [15:0]
//     0x10 CTRL      bit0 EN, bits[8+PRESC_W-1:8] DIV
//     0x14-0x1C      unmapped: bus_err=1, rdata=0, writes ignored
//
//   Bus handshake: an access is a one-cycle bus_valid pulse (bus_we selects
//   write). Exactly one cycle later bus_rvalid pulses with bus_rdata and
//   bus_err. There is no back-pressure; a new access may be issued every
//   cycle. Reads return register contents from before any same-cycle update.
//   An access presented while rst is high is dropped.
//
//   Optional feature, macro MTIMER_ATOMIC_HI_EN: a MTIME_LO read snapshots
//   mtime[47:32] into a shadow register and MTIME_HI reads return the shadow,
//   giving a tear-free 48-bit read. Without the macro MTIME_HI reads are live.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bus_valid/we/addr/wdata  access request from the LSU/bus fabric
//   bus_rvalid/rdata/err     response, one cycle after bus_valid
//   mtime                    current 48-bit count to the CSR file
//   timer_interrupt          MTIP to the CSR file (mip[7])
// -----------------------------------------------------------------------------
module rv32i_mtimer
  import rv32i_mtimer_pkg::*;
#(
  parameter int                 PRESC_W       = 8,
  parameter logic [MTIME_W-1:0] CMP_RESET     = 48'hFFFF_FFFF_FFFF,
  parameter logic               CTRL_EN_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bus_valid,
  input  logic               bus_we,
  input  logic [4:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic               bus_rvalid,
  output logic [31:0]        bus_rdata,
  output logic               bus_err,
  output logic [MTIME_W-1:0] mtime,
  output logic               timer_interrupt
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [MTIME_W-1:0] mtime_q;
  logic [MTIME_W-1:0] cmp_q;
  logic               en_q;
  logic [PRESC_W-1:0] div_q;
  logic               irq_q;
  logic               rvalid_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [2:0] word;
  logic       sel_mtime_lo;
  logic       sel_mtime_hi;
  logic       sel_cmp_lo;
  logic       sel_cmp_hi;
  logic       sel_ctrl;
  logic       mapped;
  logic       acc_wr;
  logic       acc_rd;

  assign word         = bus_addr[4:2];
  assign sel_mtime_lo = (word == MTIMER_OFF_MTIME_LO[4:2]);
  assign sel_mtime_hi = (word == MTIMER_OFF_MTIME_HI[4:2]);
  assign sel_cmp_lo   = (word == MTIMER_OFF_CMP_LO[4:2]);
  assign sel_cmp_hi   = (word == MTIMER_OFF_CMP_HI[4:2]);
  assign sel_ctrl     = (word == MTIMER_OFF_CTRL[4:2]);
  assign mapped       = sel_mtime_lo | sel_mtime_hi | sel_cmp_lo |
                        sel_cmp_hi | sel_ctrl;

  assign acc_wr = bus_valid &&  bus_we;
  assign acc_rd = bus_valid && !bus_we;

  logic wr_mtime_lo;
  logic wr_mtime_hi;
  logic wr_cmp_lo;
  logic wr_cmp_hi;
  logic wr_ctrl;

  assign wr_mtime_lo = acc_wr && sel_mtime_lo;
  assign wr_mtime_hi = acc_wr && sel_mtime_hi;
  assign wr_cmp_lo   = acc_wr && sel_cmp_lo;
  assign wr_cmp_hi   = acc_wr && sel_cmp_hi;
  assign wr_ctrl     = acc_wr && sel_ctrl;

  // Byte-lane bits of the address carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus_addr[1:0];

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic tick;

  mtimer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (en_q),
    .div   (div_q),
    .clear (wr_ctrl),
    .tick  (tick)
  );

  // ---------------------------------------------------------------------------
  // mtime: a software write to either half takes priority over a tick in the
  // same cycle; the untouched half keeps its pre-write value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= '0;
    end else if (wr_mtime_lo) begin
      mtime_q[31:0] <= bus_wdata;
    end else if (wr_mtime_hi) begin
      mtime_q[MTIME_W-1:32] <= bus_wdata[MTIME_HI_W-1:0];
    end else if (tick) begin
      mtime_q <= mtime_q + MTIME_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // mtimecmp and CTRL
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q <= CMP_RESET;
    end else if (wr_cmp_lo) begin
      cmp_q[31:0] <= bus_wdata;
    end else if (wr_cmp_hi) begin
      cmp_q[MTIME_W-1:32] <= bus_wdata[MTIME_HI_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= CTRL_EN_RESET;
      div_q <= '0;
    end else if (wr_ctrl) begin
      en_q  <= bus_wdata[CTRL_EN_BIT];
      div_q <= bus_wdata[CTRL_DIV_LSB +: PRESC_W];
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt: registered compare of the current register values. It is a
  // level and does not depend on EN, so a frozen timer past its deadline keeps
  // MTIP asserted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (mtime_q >= cmp_q);
    end
  end

  // ---------------------------------------------------------------------------
  // High-half read source
  // ---------------------------------------------------------------------------
  logic [MTIME_HI_W-1:0] hi_read;

`ifdef MTIMER_ATOMIC_HI_EN
  // Snapshot of the high half taken on every MTIME_LO read, so a LO-then-HI
  // read pair observes one consistent 48-bit value even across a carry.
  logic [MTIME_HI_W-1:0] shadow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (acc_rd && sel_mtime_lo) begin
      shadow_q <= mtime_q[MTIME_W-1:32];
    end
  end

  assign hi_read = shadow_q;
`else
  assign hi_read = mtime_q[MTIME_W-1:32];
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] ctrl_word;
  logic [31:0] rd_word;

  always_comb begin
    ctrl_word                            = '0;
    ctrl_word[CTRL_EN_BIT]               = en_q;
    ctrl_word[CTRL_DIV_LSB +: PRESC_W]   = div_q;
  end

  always_comb begin
    rd_word = '0;
    if (sel_mtime_lo) begin
      rd_word = mtime_q[31:0];
    end else if (sel_mtime_hi) begin
      rd_word[MTIME_HI_W-1:0] = hi_read;
    end else if (sel_cmp_lo) begin
      rd_word = cmp_q[31:0];
    end else if (sel_cmp_hi) begin
      rd_word[MTIME_HI_W-1:0] = cmp_q[MTIME_W-1:32];
    end else if (sel_ctrl) begin
      rd_word = ctrl_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Response: one cycle after the request. Writes and idle cycles leave
  // rdata at 0 so stale read data never lingers on the bus.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= bus_valid;
      rdata_q  <= acc_rd ? rd_word : 32'h0;
      err_q    <= bus_valid && !mapped;
    end
  end

  assign bus_rvalid      = rvalid_q;
  assign bus_rdata       = rdata_q;
  assign bus_err         = err_q;
  assign mtime           = mtime_q;
  assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_rv32i_mtimer.sv
// -----------------------------------------------------------------------------
// tb_rv32i_mtimer
//   Self-checking bench for rv32i_mtimer. A behavioural model (plain integer
//   arithmetic on the documented register rules) predicts every response.
//   Build with +define+MTIMER_ATOMIC_HI_EN to exercise the tear-free HI read.
// -----------------------------------------------------------------------------
module tb_rv32i_mtimer;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_valid = 1'b0;
  logic        bus_we = 1'b0;
  logic [4:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic [47:0] mtime;
  logic        timer_interrupt;

  always #5 clk = ~clk;

  rv32i_mtimer dut (
    .clk             (clk),
    .rst             (rst),
    .bus_valid       (bus_valid),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_rvalid      (bus_rvalid),
    .bus_rdata       (bus_rdata),
    .bus_err         (bus_err),
    .mtime           (mtime),
    .timer_interrupt (timer_interrupt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  longint unsigned m_time;      // mtime as a plain number, kept modulo 2^48
  longint unsigned m_cmp;
  bit              m_en;
  int              m_div;
  int              m_since;     // cycles elapsed in the current tick period
  bit              m_irq;
  int              m_shadow;
  bit              m_rvalid;
  longint unsigned m_rdata;
  bit              m_err;

  localparam longint unsigned WRAP = 64'h1_0000_0000_0000;

  task automatic model_step(input bit r, input bit v, input bit we,
                            input int addr, input longint unsigned wd);
    int              reg_no;
    bit              ctrl_wr;
    bit              tick;
    longint unsigned t_next;
    if (r) begin
      m_time = 0; m_cmp = WRAP - 1; m_en = 1; m_div = 0; m_since = 0;
      m_irq = 0; m_shadow = 0; m_rvalid = 0; m_rdata = 0; m_err = 0;
      return;
    end
    reg_no  = addr / 4;
    ctrl_wr = v && we && reg_no == 4;
    // response from values before this cycle's update
    m_rvalid = v;
    m_err    = v && reg_no > 4;
    m_rdata  = 0;
    if (v && !we) begin
      case (reg_no)
        0: m_rdata = m_time % 64'h1_0000_0000;
`ifdef MTIMER_ATOMIC_HI_EN
        1: m_rdata = m_shadow;
`else
        1: m_rdata = m_time / 64'h1_0000_0000;
`endif
        2: m_rdata = m_cmp % 64'h1_0000_0000;
        3: m_rdata = m_cmp / 64'h1_0000_0000;
        4: m_rdata = m_div * 256 + m_en;
        default: m_rdata = 0;
      endcase
      if (reg_no == 0) m_shadow = int'(m_time / 64'h1_0000_0000);
    end
    // tick every (div+1) enabled cycles; a CTRL write restarts the period
    tick = m_en && !ctrl_wr && m_since == m_div;
    t_next = m_time;
    if (v && we && reg_no == 0)
      t_next = (m_time / 64'h1_0000_0000) * 64'h1_0000_0000 + (wd % 64'h1_0000_0000);
    else if (v && we && reg_no == 1)
      t_next = (wd % 65536) * 64'h1_0000_0000 + (m_time % 64'h1_0000_0000);
    else if (tick)
      t_next = (m_time + 1) % WRAP;
    if (ctrl_wr) m_since = 0;
    else if (m_en) m_since = tick ? 0 : m_since + 1;
    m_irq = (m_time >= m_cmp);
    if (v && we && reg_no == 2)
      m_cmp = (m_cmp / 64'h1_0000_0000) * 64'h1_0000_0000 + (wd % 64'h1_0000_0000);
    if (v && we && reg_no == 3)
      m_cmp = (wd % 65536) * 64'h1_0000_0000 + (m_cmp % 64'h1_0000_0000);
    if (ctrl_wr) begin
      m_en  = wd[0];
      m_div = int'((wd / 256) % 256);
    end
    m_time = t_next;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input bit r, input bit v, input bit we,
                      input logic [4:0] a, input logic [31:0] wd);
    rst = r; bus_valid = v; bus_we = we; bus_addr = a; bus_wdata = wd;
    model_step(r, v, we, int'(a), longint'(wd));
    @(posedge clk);
    #1;
    rst = 1'b0; bus_valid = 1'b0; bus_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 5'h0, 32'h0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(0, 1, 1, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    step(0, 1, 0, a, 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    step(1, 0, 0, 5'h0, 32'h0);
    step(1, 1, 0, 5'h0, 32'h0);   // access during reset is dropped
    n_checks++;
    if (mtime !== 48'h0) begin n_fail++; $display("FAIL reset_mtime: got %h want 0", mtime); end
    n_checks++;
    if (timer_interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", timer_interrupt); end
    n_checks++;
    if (bus_rvalid !== 1'b0 || bus_rdata !== 32'h0 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_bus: rvalid %b rdata %h err %b want 0/0/0", bus_rvalid, bus_rdata, bus_err);
    end
    rd(5'h00);
    n_checks++;
    if (bus_rvalid !== 1'b1 || bus_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd_mtime_lo: rvalid %b rdata %h want 1/00000000", bus_rvalid, bus_rdata);
    end
    rd(5'h08);
    n_checks++;
    if (bus_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_rd_cmp_lo: got %h want ffffffff", bus_rdata); end
    rd(5'h0C);
    n_checks++;
    if (bus_rdata !== 32'h0000_FFFF) begin n_fail++; $display("FAIL reset_rd_cmp_hi: got %h want 0000ffff", bus_rdata); end
    n_checks++;
    if (timer_interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_irq_after: got %b want 0", timer_interrupt); end
    n_checks++;
    if (mtime !== 48'd3) begin n_fail++; $display("FAIL reset_running: got %0d want 3", mtime); end
    // reset asserted together with an access: no response next cycle
    step(1, 1, 0, 5'h00, 32'h0);
    n_checks++;
    if (bus_rvalid !== 1'b0 || mtime !== 48'h0) begin
      n_fail++; $display("FAIL reset_mid_access: rvalid %b mtime %h want 0/0", bus_rvalid, mtime);
    end
  endtask

  task automatic test_prescale();
    wr(5'h10, 32'h0);          // EN=0
    wr(5'h00, 32'h0);
    wr(5'h04, 32'h0);
    idle(5);
    n_checks++;
    if (mtime !== 48'h0) begin n_fail++; $display("FAIL freeze: got %h want 0", mtime); end
    wr(5'h10, 32'h0000_0301);  // DIV=3, EN=1
    for (int i = 0; i < 40; i++) begin
      idle(1);
      n_checks++;
      if (mtime !== m_time[47:0]) begin
        n_fail++; $display("FAIL prescale_cycle%0d: got %0d want %0d", i, mtime, m_time);
      end
    end
    n_checks++;
    if (mtime !== 48'd10) begin n_fail++; $display("FAIL prescale_40: got %0d want 10", mtime); end
    rd(5'h10);
    n_checks++;
    if (bus_rdata !== 32'h0000_0301 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL ctrl_readback: rdata %h err %b want 00000301/0", bus_rdata, bus_err);
    end
  endtask

  task automatic test_interrupt();
    int guard;
    wr(5'h10, 32'h0);
    wr(5'h00, 32'h0);
    wr(5'h0C, 32'h0);
    wr(5'h08, 32'd20);
    wr(5'h10, 32'h1);          // EN=1, DIV=0
    guard = 0;
    while (m_time != 20 && guard < 100) begin
      idle(1);
      guard++;
    end
    n_checks++;
    if (mtime !== 48'd20 || timer_interrupt !== 1'b0) begin
      n_fail++; $display("FAIL irq_at_20: mtime %0d irq %b want 20/0", mtime, timer_interrupt);
    end
    idle(1);
    n_checks++;
    if (timer_interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b want 1", timer_interrupt); end
    wr(5'h08, 32'hFFFF_FFFF);
    n_checks++;
    if (timer_interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b want 1", timer_interrupt); end
    idle(1);
    n_checks++;
    if (timer_interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b want 0", timer_interrupt); end
  endtask

  task automatic test_wrap();
    wr(5'h04, 32'h0000_FFFF);
    wr(5'h00, 32'hFFFF_FFFE);
    n_checks++;
    if (mtime !== 48'hFFFF_FFFF_FFFE) begin n_fail++; $display("FAIL wrap_set: got %h want fffffffffffe", mtime); end
    idle(1);
    n_checks++;
    if (mtime !== 48'hFFFF_FFFF_FFFF) begin n_fail++; $display("FAIL wrap_max: got %h want ffffffffffff", mtime); end
    idle(1);
    n_checks++;
    if (mtime !== 48'h0) begin n_fail++; $display("FAIL wrap_zero: got %h want 0", mtime); end
    n_checks++;
    if (timer_interrupt !== 1'b1) begin n_fail++; $display("FAIL wrap_irq_hold: got %b want 1", timer_interrupt); end
    idle(1);
    n_checks++;
    if (timer_interrupt !== 1'b0) begin n_fail++; $display("FAIL wrap_irq_drop: got %b want 0", timer_interrupt); end
  endtask

  task automatic test_collision();
    wr(5'h00, 32'd5);          // DIV=0: this cycle would also tick
    n_checks++;
    if (mtime !== 48'd5) begin n_fail++; $display("FAIL collide_write: got %0d want 5", mtime); end
    idle(1);
    n_checks++;
    if (mtime !== 48'd6) begin n_fail++; $display("FAIL collide_next: got %0d want 6", mtime); end
  endtask

  task automatic test_unmapped();
    rd(5'h18);
    n_checks++;
    if (bus_err !== 1'b1 || bus_rdata !== 32'h0 || bus_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL unmapped_rd: err %b rdata %h rvalid %b want 1/0/1", bus_err, bus_rdata, bus_rvalid);
    end
    wr(5'h14, $urandom());
    n_checks++;
    if (bus_err !== 1'b1 || mtime !== m_time[47:0]) begin
      n_fail++; $display("FAIL unmapped_wr: err %b mtime %h want 1/%h", bus_err, mtime, m_time[47:0]);
    end
    rd(5'h1B);
    n_checks++;
    if (bus_err !== 1'b1) begin n_fail++; $display("FAIL unmapped_1b: err %b want 1", bus_err); end
    rd(5'h10);
    n_checks++;
    if (bus_err !== 1'b0 || bus_rdata !== 32'h1) begin
      n_fail++; $display("FAIL ctrl_rd: err %b rdata %h want 0/00000001", bus_err, bus_rdata);
    end
  endtask

  task automatic test_atomic_read();
    wr(5'h10, 32'h0);
    wr(5'h04, 32'h0);
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h10, 32'h1);
    rd(5'h00);
    n_checks++;
    if (bus_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL atomic_lo: got %h want ffffffff", bus_rdata); end
    rd(5'h04);
    n_checks++;
`ifdef MTIMER_ATOMIC_HI_EN
    if (bus_rdata !== 32'h0) begin n_fail++; $display("FAIL atomic_hi: got %h want 00000000", bus_rdata); end
`else
    if (bus_rdata !== 32'h1) begin n_fail++; $display("FAIL live_hi: got %h want 00000001", bus_rdata); end
`endif
    n_checks++;
    if (mtime !== 48'h1_0000_0001) begin n_fail++; $display("FAIL atomic_mtime: got %h want 000100000001", mtime); end
  endtask

  task automatic test_random();
    bit          r, v, we;
    logic [4:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 40) == 0);
      v  = ($urandom_range(0, 2) != 0);
      we = ($urandom_range(0, 1) == 1);
      a  = 5'($urandom_range(0, 31));
      d  = $urandom();
      if (a[4:2] == 3'd4) d = {16'h0, 8'($urandom_range(0, 4)), 7'h0, ($urandom_range(0, 5) != 0)};
      step(r, v, we, a, d);
      n_checks++;
      if (mtime !== m_time[47:0]) begin n_fail++; $display("FAIL rand%0d_mtime: got %h want %h", i, mtime, m_time[47:0]); end
      n_checks++;
      if (timer_interrupt !== m_irq) begin n_fail++; $display("FAIL rand%0d_irq: got %b want %b", i, timer_interrupt, m_irq); end
      n_checks++;
      if (bus_rvalid !== m_rvalid) begin n_fail++; $display("FAIL rand%0d_rvalid: got %b want %b", i, bus_rvalid, m_rvalid); end
      n_checks++;
      if (bus_rdata !== m_rdata[31:0]) begin n_fail++; $display("FAIL rand%0d_rdata: got %h want %h", i, bus_rdata, m_rdata[31:0]); end
      n_checks++;
      if (bus_err !== m_err) begin n_fail++; $display("FAIL rand%0d_err: got %b want %b", i, bus_err, m_err); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_prescale();
    test_interrupt();
    test_wrap();
    test_collision();
    test_unmapped();
    test_atomic_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
